// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - parametrised 16x-oversampling UART receiver with valid/ready word output
// Optional feature macro: UART_RX_MAJORITY_EN (2-of-3 majority of rxs at ticks 7, 8 and 9).
module uart_rx_frame #(
    parameter int F         = 8000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int DIV   = (F + BAUD * 8) / (BAUD * 16);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    generate
        if (DIV < 1) begin : g_div_check
            $error("uart_rx_frame: F / (BAUD*16) rounds to less than 1");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_check
            $error("uart_rx_frame: DATA_BITS must be 5..9");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_check
            $error("uart_rx_frame: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state;
    logic                 rx_meta, rxs, rxs_prev;
    logic [DIV_W-1:0]     div_cnt;
    logic [3:0]           samp_cnt;
    logic [3:0]           bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad, stop_bad;
    logic                 tick, sample_now, bit_val, start_det, exp_par;

`ifdef UART_RX_MAJORITY_EN
    // Decision waits for the tick that ends bit-time 9 so all three samples exist.
    localparam logic [3:0] DEC_CNT = 4'd8;
    logic s7, s8;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s7 <= 1'b1;
            s8 <= 1'b1;
        end else if (tick) begin
            if (samp_cnt == 4'd6) s7 <= rxs;
            if (samp_cnt == 4'd7) s8 <= rxs;
        end
    end

    assign bit_val = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
`else
    localparam logic [3:0] DEC_CNT = 4'd7;
    assign bit_val = rxs;
`endif

    // samp_cnt holds the number of ticks seen in the current bit; the tick that makes it 8 samples.
    assign tick       = (div_cnt == DIV_W'(DIV - 1));
    assign sample_now = tick && (samp_cnt == DEC_CNT);
    assign start_det  = (state == IDLE) && rxs_prev && !rxs;
    assign exp_par    = (PARITY == 2) ? ^shreg : ~^shreg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt  <= '0;
            samp_cnt <= '0;
        end else if (start_det) begin
            div_cnt  <= '0;
            samp_cnt <= '0;
        end else if (tick) begin
            div_cnt  <= '0;
            samp_cnt <= samp_cnt + 4'd1;
        end else begin
            div_cnt  <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta    <= 1'b1;
            rxs        <= 1'b1;
            rxs_prev   <= 1'b1;
            state      <= IDLE;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            stop_bad   <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rxs      <= rx_meta;
            rxs_prev <= rxs;

            // A drop needs !ready, so it can never coincide with this accept.
            if (valid && ready) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start_det) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (sample_now) begin
                        if (bit_val) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state    <= DATA;
                            bit_idx  <= '0;
                            stop_idx <= 1'b0;
                            par_bad  <= 1'b0;
                            stop_bad <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (sample_now) begin
                        shreg <= {bit_val, shreg[DATA_BITS-1:1]};
                        if (bit_idx == 4'(DATA_BITS - 1)) begin
                            state <= (PARITY != 0) ? PAR : STOP;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                end
                PAR: begin
                    if (sample_now) begin
                        par_bad <= (bit_val != exp_par);
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (sample_now) begin
                        if (stop_idx == STOP_LAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (!valid || ready) begin
                                data_out   <= shreg;
                                parity_err <= par_bad;
                                frame_err  <= stop_bad | ~bit_val;
                                valid      <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            stop_bad <= stop_bad | ~bit_val;
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - self-checking bench for uart_rx_frame (8N1 and 7E2 instances)
module tb_uart_rx_frame;
    localparam int F    = 18432000;
    localparam int BAUD = 115200;
    localparam int DIV  = 10;
    localparam int BIT  = 16 * DIV;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    localparam int LAT_A = (2 * (1 + 8 + 0 + 1) - 1) * 8 * DIV + 3 + MAJ * DIV;
    localparam int LAT_B = (2 * (1 + 7 + 1 + 2) - 1) * 8 * DIV + 3 + MAJ * DIV;

    typedef struct packed {
        logic [8:0]  d;
        logic        pe;
        logic        fe;
        logic [31:0] cyc;
    } word_t;

    logic       clk, rst;
    logic       rx_a, ready_a, valid_a, pe_a, fe_a, ovr_a, busy_a;
    logic [7:0] dout_a;
    logic       rx_b, ready_b, valid_b, pe_b, fe_b, ovr_b, busy_b;
    logic [6:0] dout_b;

    int    passed = 0;
    int    failed = 0;
    int    total  = 0;
    int    cyc    = 0;
    int    start_cyc = 0;
    int    vcnt_a = 0;
    word_t qa[$];
    word_t qb[$];
    word_t ma, mb;

    uart_rx_frame #(.F(F), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .data_out(dout_a), .valid(valid_a), .ready(ready_a),
        .parity_err(pe_a), .frame_err(fe_a), .overrun(ovr_a), .busy(busy_a)
    );

    uart_rx_frame #(.F(F), .BAUD(BAUD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .data_out(dout_b), .valid(valid_b), .ready(ready_b),
        .parity_err(pe_b), .frame_err(fe_b), .overrun(ovr_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Accepted words are logged on the falling edge, between input drives and DUT edges.
    always @(negedge clk) begin
        if (rst && valid_a) vcnt_a++;
        if (rst && valid_a && ready_a) begin
            ma.d = {1'b0, dout_a}; ma.pe = pe_a; ma.fe = fe_a; ma.cyc = cyc;
            qa.push_back(ma);
        end
        if (rst && valid_b && ready_b) begin
            mb.d = {2'b00, dout_b}; mb.pe = pe_b; mb.fe = fe_b; mb.cyc = cyc;
            qb.push_back(mb);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx_b = v; else rx_a = v;
        wait_clk(BIT);
    endtask

    task automatic send(input bit sel, input logic [8:0] d, input int nb, input int pmode,
                        input logic pbit, input int ns, input logic [1:0] sv);
        start_cyc = cyc;
        drive(sel, 1'b0);
        for (int i = 0; i < nb; i++) drive(sel, d[i]);
        if (pmode != 0) drive(sel, pbit);
        for (int i = 0; i < ns; i++) drive(sel, sv[i]);
        if (sel) rx_b = 1'b1; else rx_a = 1'b1;
    endtask

    // Expected {data, parity_err, frame_err} from the frame's bit contents.
    function automatic logic [10:0] model(input logic [8:0] d, input int nb, input int pmode,
                                          input logic pbit, input int ns, input logic [1:0] sv);
        int ones;
        logic [8:0] dm;
        logic want, pe, fe;
        ones = 0;
        dm = '0;
        for (int i = 0; i < nb; i++) begin
            dm[i] = d[i];
            if (d[i]) ones++;
        end
        want = (pmode == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
        pe = (pmode != 0) && (pbit != want);
        fe = !sv[0] || (ns == 2 && !sv[1]);
        return {dm, pe, fe};
    endfunction

    task automatic expect_word(input bit sel, input string tag, input logic [10:0] exp, input int lat);
        word_t w;
        int n;
        n = sel ? qb.size() : qa.size();
        chk({tag, "_count"}, n, 1);
        w = 'x;
        if (n > 0) begin
            if (sel) w = qb.pop_front();
            else     w = qa.pop_front();
        end
        chk(tag, {21'd0, w.d, w.pe, w.fe}, {21'd0, exp});
        if (lat > 0) chk({tag, "_latency"}, w.cyc - start_cyc, lat);
    endtask

    initial begin
        logic [8:0] d;
        logic [1:0] sv;
        logic       pb;
        rst = 1'b0; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
        wait_clk(3);
        chk("reset_a", {valid_a, dout_a, pe_a, fe_a, ovr_a, busy_a}, 0);
        chk("reset_b", {valid_b, dout_b, pe_b, fe_b, ovr_b, busy_b}, 0);
        rst = 1'b1;
        wait_clk(20);

        vcnt_a = 0;
        send(0, 9'h0A5, 8, 0, 1'b0, 1, 2'b11);
        expect_word(0, "a5", model(9'h0A5, 8, 0, 1'b0, 1, 2'b11), LAT_A);
        chk("a5_pulse", vcnt_a, 1);
        chk("a5_idle", {valid_a, busy_a}, 0);

        send(1, 9'h041, 7, 2, 1'b1, 2, 2'b11);
        expect_word(1, "par_bad", model(9'h041, 7, 2, 1'b1, 2, 2'b11), LAT_B);
        wait_clk(7);
        send(1, 9'h041, 7, 2, 1'b0, 2, 2'b11);
        expect_word(1, "par_good", model(9'h041, 7, 2, 1'b0, 2, 2'b11), LAT_B);

        wait_clk(30);
        rx_a = 1'b0;
        wait_clk(40);
        rx_a = 1'b1;
        wait_clk(200);
        chk("glitch_none", qa.size(), 0);
        chk("glitch_busy", busy_a, 0);
        send(0, 9'h03C, 8, 0, 1'b0, 1, 2'b11);
        expect_word(0, "after_glitch", model(9'h03C, 8, 0, 1'b0, 1, 2'b11), LAT_A);

        ready_a = 1'b0;
        send(0, 9'h011, 8, 0, 1'b0, 1, 2'b11);
        send(0, 9'h022, 8, 0, 1'b0, 1, 2'b11);
        wait_clk(5);
        chk("ovr_hold", {valid_a, dout_a, ovr_a}, {1'b1, 8'h11, 1'b1});
        chk("ovr_none", qa.size(), 0);
        ready_a = 1'b1;
        wait_clk(1);
        ready_a = 1'b0;
        chk("ovr_clear", {valid_a, ovr_a}, 0);
        expect_word(0, "ovr_word", model(9'h011, 8, 0, 1'b0, 1, 2'b11), 0);
        ready_a = 1'b1;

        wait_clk(10);
        send(0, 9'h080, 8, 0, 1'b0, 1, 2'b00);
        wait_clk(100);
        expect_word(0, "stop0", model(9'h080, 8, 0, 1'b0, 1, 2'b00), 0);
        rx_a = 1'b0;
        wait_clk(3 * 10 * BIT);
        rx_a = 1'b1;
        wait_clk(50);
        expect_word(0, "break", model(9'h000, 8, 0, 1'b0, 1, 2'b00), 0);
        chk("break_idle", busy_a, 0);

        ready_a = 1'b0;
        send(0, 9'h0C3, 8, 0, 1'b0, 1, 2'b11);
        wait_clk(5);
        chk("hold_c3", {valid_a, dout_a}, {1'b1, 8'hC3});
        drive(0, 1'b0);
        drive(0, 1'b1);
        drive(0, 1'b1);
        drive(0, 1'b1);
        chk("busy_mid", busy_a, 1);
        rst = 1'b0;
        #1;
        chk("rst_async", {valid_a, dout_a, pe_a, fe_a, ovr_a, busy_a}, 0);
        wait_clk(20);
        rst = 1'b1;
        ready_a = 1'b1;
        wait_clk(1000);
        chk("rst_drop", qa.size(), 0);
        send(0, 9'h05A, 8, 0, 1'b0, 1, 2'b11);
        expect_word(0, "after_rst", model(9'h05A, 8, 0, 1'b0, 1, 2'b11), LAT_A);

        for (int i = 0; i < 6; i++) begin
            d  = 9'($urandom_range(0, 255));
            sv = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
            wait_clk($urandom_range(1, 50));
            send(0, d, 8, 0, 1'b0, 1, sv);
            expect_word(0, $sformatf("rand_a%0d", i), model(d, 8, 0, 1'b0, 1, sv), LAT_A);
        end
        for (int i = 0; i < 6; i++) begin
            d  = 9'($urandom_range(0, 127));
            pb = 1'($urandom_range(0, 1));
            sv = 2'($urandom_range(0, 3));
            wait_clk($urandom_range(1, 50));
            send(1, d, 7, 2, pb, 2, sv);
            expect_word(1, $sformatf("rand_b%0d", i), model(d, 7, 2, pb, 2, sv), LAT_B);
        end

        wait_clk(200);
        chk("end_qa", qa.size(), 0);
        chk("end_qb", qb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receiver, the successor to the fixed 8N1 receiver used in the FPGA experiments. It deserialises asynchronous serial frames with configurable data width, parity and stop bits, using 16× oversampling. Each received word is presented on a valid/ready output port together with per-word parity and framing error flags. It sits between the board RX pin and any byte-consuming logic, such as a FIFO or command decoder.

## Interface
- F, 8000000 — system clock frequency in Hz
- BAUD, 115200 — line rate in bit/s
- DATA_BITS, 8 — data bits per frame, legal range 5–9
- PARITY, 0 — 0 none, 1 odd, 2 even
- STOP_BITS, 1 — stop bits, legal values 1 or 2
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active low
- rx  input  1  serial line, idle high, asynchronous to clk
- data_out  output  DATA_BITS  received word, LSB first on the line
- valid  output  1  data_out and flags hold a word
- ready  input  1  consumer accepts the word when valid && ready
- parity_err  output  1  parity mismatch for the current word
- frame_err  output  1  first stop bit sampled low for the current word
- overrun  output  1  sticky flag: a frame was dropped because valid was still high
- busy  output  1  receiver is not in IDLE

## Operation
- rx passes through a 2-FF synchroniser, whose output is called rxs.
- Tick divider: DIV = round(F / (BAUD*16)), with an elaboration error if DIV < 1.
  - Emits a one-clk tick every DIV clk.
  - Reloads to 0 on start detection, so ticks are phase-aligned to the start edge.
- Sample counter: 4 bits, counts ticks 0–15 within each bit; the bit value is taken at tick 8.
- State machine: IDLE → START → DATA → PAR (only when PARITY≠0) → STOP → IDLE.
- IDLE:
  - A falling edge on rxs (previous 1, current 0) moves to START and clears the counters.
- START:
  - At tick 8, if the sample is 1, this is a false start; return to IDLE with no output.
  - If the sample is 0, go to DATA with the bit index at 0.
- DATA:
  - At each bit's tick 8, shift the sample into the MSB of a DATA_BITS shift register.
  - After DATA_BITS bits, go to PAR or STOP.
- PAR: the expected bit is XOR of the data bits for even parity and XNOR for odd; a mismatch gives parity_err for this word.
- STOP:
  - The first stop bit is sampled at tick 8; 0 gives frame_err.
  - With STOP_BITS=2, the second stop bit is also checked; a 0 in either stop bit gives frame_err.
  - The word is delivered after the last stop-bit sample, then the state returns to IDLE immediately, without waiting out the bit. This absorbs up to half a bit of clock mismatch per frame.
- Delivery:
  - If valid=0, or if valid && ready in the same cycle: load data_out, parity_err and frame_err, and set valid=1.
  - If valid=1 && !ready: the new frame is dropped, the held word is unchanged, and overrun is set to 1.
- Handshake:
  - valid && ready clears valid on the next edge.
  - data_out and the flags are stable while valid=1.
  - overrun clears only on an accepted transfer that is not simultaneous with another drop.
- A break (rx low continuously) produces one word of all zeros with frame_err=1, then stays in IDLE until rxs returns high and falls again.

## Timing
- Reset (rst=0): all outputs are 0, the state is IDLE and the synchroniser resets to 1. The effect is immediate and independent of clk.
- Releasing reset mid-frame resumes in IDLE; the partial frame is lost and line activity is ignored until the next falling edge.
- rx-to-detection latency: 2 clk for the synchroniser plus 1 clk for edge detection.
- valid rises 1 clk after the tick-8 sample of the last stop bit.
- Total frame latency from the start edge: (1 + DATA_BITS + (PARITY?1:0) + STOP_BITS − 0.5) × 16 × DIV clk, +3 clk.
- busy goes high on the clk after start detection and low in the same cycle that valid is loaded.

## Configuration
- UART_RX_MAJORITY_EN:
  - Defined: every sampled bit (start, data, parity, stop) is the 2-of-3 majority of rxs at ticks 7, 8 and 9. The decision and all actions move to tick 9, and every latency above grows by 1 × DIV clk.
  - Undefined: a single sample at tick 8, exactly as described above.

## Test plan
- F=18432000, BAUD=115200 (DIV=10), 8N1, send 0xA5 with ready=1 → after the stop-bit sample, valid pulses 1 clk with data_out=0xA5 and both flags 0.
- PARITY=2, DATA_BITS=7, send 0x41 with a wrong parity bit 1 → data_out=0x41, parity_err=1. Resend with parity 0 → parity_err=0.
- Drive a 40-clk low glitch on rx in IDLE → no valid, busy returns to 0, and the next 0x3C frame is received correctly.
- Hold ready=0 and send 0x11 then 0x22 → data_out stays 0x11 and overrun=1. Assert ready for 1 clk → valid=0, overrun=0.
- Send a frame with stop bit 0 (data 0x80) → frame_err=1 with data_out=0x80. Hold rx low for 3 frame times → exactly one extra word, 0x00 with frame_err=1.
- Assert rst=0 mid-DATA while sending 0xFF → outputs are 0 at once. Release reset and send 0x5A → only 0x5A is delivered.
